// File: rtl/seq_pattern_generator_pkg.sv
// Shared definitions for the serial pattern generator.
// Holds the FSM state encoding and the default parameter widths used by
// seq_pattern_generator and seq_gen_shifter.
package seq_gen_pkg;
  localparam int MAX_LEN_DEF = 8;  // pattern register width
  localparam int LEN_W_DEF   = 4;  // pat_len width, must hold MAX_LEN
  localparam int REP_W_DEF   = 8;  // rep_count width
  localparam int GAP_W_DEF   = 4;  // gap_len width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/seq_pattern_generator_if.sv
// Serial output stream of the pattern generator.
//   bit_out   : serial data bit
//   bit_valid : bit_out is valid
//   last_bit  : final bit of a repetition (qualified by bit_valid)
//   ready     : sink accepts bit_out this cycle
// master = generator side, slave = sink side.
interface seq_pattern_generator_if;
  logic bit_out;
  logic bit_valid;
  logic last_bit;
  logic ready;

  modport master (output bit_out, output bit_valid, output last_bit, input ready);
  modport slave  (input bit_out, input bit_valid, input last_bit, output ready);
endinterface

// File: rtl/seq_gen_shifter.sv
// Pattern shift register with bit-index down-counter.
//   load_i      : load pattern_i, left-aligned so bit [len_i-1] appears first
//   load_fill_i : load all bits with fill_i (gap mode, last_o stays 0)
//   advance_i   : shift to the next bit
//   bit_o       : current bit (MSB of the shift register)
//   last_o      : current bit is bit 0 of the pattern
// Both outputs come straight from flops. len_i must be 1..MAX_LEN on load.
module seq_gen_shifter
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               load_fill_i,
  input  logic               advance_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               fill_i,
  output logic               bit_o,
  output logic               last_o
);
  logic [MAX_LEN-1:0] sr_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               last_q;
  logic               fill_mode_q;
  logic [LEN_W-1:0]   sh_amt;

  assign sh_amt = LEN_W'(MAX_LEN) - len_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      fill_mode_q <= 1'b0;
    end else if (load_i) begin
      sr_q        <= pattern_i << sh_amt;
      cnt_q       <= len_i - LEN_W'(1);
      last_q      <= (len_i == LEN_W'(1));
      fill_mode_q <= 1'b0;
    end else if (load_fill_i) begin
      sr_q        <= {MAX_LEN{fill_i}};
      cnt_q       <= '0;
      last_q      <= 1'b0;
      fill_mode_q <= 1'b1;
    end else if (advance_i) begin
      // Replicating the LSB keeps a fill word constant for any gap length.
      sr_q   <= {sr_q[MAX_LEN-2:0], sr_q[0]};
      cnt_q  <= cnt_q - LEN_W'(1);
      last_q <= !fill_mode_q && (cnt_q == LEN_W'(1));
    end
  end

  assign bit_o  = sr_q[MAX_LEN-1];
  assign last_o = last_q;
endmodule

// File: rtl/seq_pattern_generator.sv
// Serial pattern transmitter: sends a pattern MSB-first rep_count times with
// optional gap_len fill bits between repetitions, 1 bit/cycle with valid/ready.
//   clk, reset           : clock, async active-high reset
//   start                : request a burst (taken only while busy=0)
//   pattern, pat_len     : pattern bits and length (clamped to MAX_LEN)
//   rep_count            : number of repetitions
//   gap_len, gap_fill    : fill bits between repetitions and their value
//   busy, done           : burst in progress / 1-cycle completion pulse
//   stream (master)      : bit_out, bit_valid, last_bit, ready
module seq_pattern_generator
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int REP_W   = REP_W_DEF,
  parameter int GAP_W   = GAP_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [MAX_LEN-1:0]     pattern,
  input  logic [LEN_W-1:0]       pat_len,
  input  logic [REP_W-1:0]       rep_count,
  input  logic [GAP_W-1:0]       gap_len,
  input  logic                   gap_fill,
  output logic                   busy,
  output logic                   done,
  seq_pattern_generator_if.master stream
);
  state_e             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [REP_W-1:0]   rep_q;
  logic [GAP_W-1:0]   gap_len_q;
  logic [GAP_W-1:0]   gap_q;
  logic               fill_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;

  logic [LEN_W-1:0]   len_c;
  logic               accept, degen, xfer, end_rep, more_reps;
  logic               sh_load, sh_load_fill, sh_bit, sh_last;

  assign len_c     = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;
  // DONE also has busy=0, so a start there begins the next burst directly.
  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign degen     = (len_c == '0) || (rep_count == '0);
  assign xfer      = valid_q && stream.ready;
  assign end_rep   = xfer && sh_last && (state_q == SHIFT);
  assign more_reps = (rep_q != REP_W'(1));

  assign sh_load      = (accept && !degen)
                      || (end_rep && more_reps && gap_len_q == '0)
                      || (state_q == GAP && xfer && gap_q == GAP_W'(1));
  assign sh_load_fill = end_rep && more_reps && (gap_len_q != '0);

  seq_gen_shifter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .load_i      (sh_load),
    .load_fill_i (sh_load_fill),
    .advance_i   (xfer),
    .pattern_i   (accept ? pattern : pat_q),
    .len_i       (accept ? len_c : len_q),
    .fill_i      (fill_q),
    .bit_o       (sh_bit),
    .last_o      (sh_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      gap_len_q <= '0;
      gap_q     <= '0;
      fill_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            pat_q     <= pattern;
            len_q     <= len_c;
            rep_q     <= rep_count;
            gap_len_q <= gap_len;
            fill_q    <= gap_fill;
            if (degen) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (end_rep) begin
            rep_q <= rep_q - REP_W'(1);
            if (!more_reps) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (gap_len_q != '0) begin
              state_q <= GAP;
              gap_q   <= gap_len_q;
            end
          end
        end
        GAP: begin
          if (xfer) begin
            if (gap_q == GAP_W'(1)) state_q <= SHIFT;
            else                    gap_q   <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stream.bit_out   = sh_bit;
  assign stream.last_bit  = sh_last;
  assign stream.bit_valid = valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
endmodule
